// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, scheduler states, address helpers
// and default timing used by the controller blocks.
package sdram_pkg;

  localparam int BANK_BITS      = 2;
  localparam int ROW_BITS       = 13;
  localparam int COL_BITS       = 10;
  localparam int ADDR_BITS      = BANK_BITS + ROW_BITS + COL_BITS;
  localparam int DRAM_ADDR_BITS = 13;
  localparam int AP_BIT         = 10;

  localparam int BURST_LENGTH     = 4;
  localparam int CAS_LATENCY      = 3;
  localparam int T_RCD            = 2;
  localparam int T_RP             = 2;
  localparam int T_WR             = 2;
  localparam int T_RC             = 7;
  localparam int REFRESH_INTERVAL = 780;

  // {CS_N, RAS_N, CAS_N, WE_N}
  typedef enum logic [3:0] {
    CMD_MRS   = 4'b0000,
    CMD_REF   = 4'b0001,
    CMD_PRE   = 4'b0010,
    CMD_ACT   = 4'b0011,
    CMD_WRITE = 4'b0100,
    CMD_READ  = 4'b0101,
    CMD_NOP   = 4'b0111
  } cmd_t;

  typedef enum logic [2:0] {
    ST_WAIT_INIT,
    ST_READY,
    ST_WAIT_RC,
    ST_WAIT_RCD,
    ST_ACCESS,
    ST_WAIT_DONE
  } state_t;

  function automatic logic [BANK_BITS-1:0] addr_bank(input logic [ADDR_BITS-1:0] a);
    return a[ADDR_BITS-1 -: BANK_BITS];
  endfunction

  function automatic logic [ROW_BITS-1:0] addr_row(input logic [ADDR_BITS-1:0] a);
    return a[COL_BITS +: ROW_BITS];
  endfunction

  function automatic logic [COL_BITS-1:0] addr_col(input logic [ADDR_BITS-1:0] a);
    return a[COL_BITS-1:0];
  endfunction

  // Column address with the auto-precharge bit set.
  function automatic logic [DRAM_ADDR_BITS-1:0] col_ap_addr(input logic [COL_BITS-1:0] col);
    logic [DRAM_ADDR_BITS-1:0] r;
    r               = '0;
    r[COL_BITS-1:0] = col;
    r[AP_BIT]       = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/sdram_scheduler_if.sv
// Requester-side bus of the scheduler: two request ports plus the data-phase
// strobes consumed by the external DQ datapath.
interface sdram_scheduler_if
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_BITS
);
  logic [1:0]             req_valid;
  logic [1:0]             req_we;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0]             req_ready;
  logic                   wr_data_req;
  logic                   rd_data_valid;
  logic                   data_port;

  modport master (
    output req_valid, req_we, req_addr,
    input  req_ready, wr_data_req, rd_data_valid, data_port
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    output req_ready, wr_data_req, rd_data_valid, data_port
  );
endinterface

// File: rtl/sdram_refresh_timer.sv
// Auto-refresh interval counter with a single sticky pending flag; a terminal
// count while already pending does not build up extra refresh debt.
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int refresh_interval = REFRESH_INTERVAL
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic refresh_ack,
  output logic refresh_pending
);
  localparam int CNT_W = $clog2(refresh_interval);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(refresh_interval - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             terminal;

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    terminal  = enable && (cnt_q == LAST);
    if (enable) begin
      cnt_d = terminal ? '0 : cnt_q + CNT_W'(1);
    end
    if (refresh_ack) begin
      pending_d = 1'b0;
    end
    // A terminal count coinciding with the acknowledge re-arms the request.
    if (terminal) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign refresh_pending = pending_q;

endmodule

// File: rtl/sdram_scheduler.sv
// Runtime SDRAM command scheduler: round-robin between two ports, refresh first,
// closed-page ACT followed by READA/WRITEA, with DQ data-phase strobes.
module sdram_scheduler
  import sdram_pkg::*;
#(
  parameter int bank_count       = BANK_BITS,
  parameter int row_count        = ROW_BITS,
  parameter int column_count     = COL_BITS,
  parameter int burst_length     = BURST_LENGTH,
  parameter int CAS_Latency      = CAS_LATENCY,
  parameter int t_rcd            = T_RCD,
  parameter int t_rp             = T_RP,
  parameter int t_wr             = T_WR,
  parameter int t_rc             = T_RC,
  parameter int refresh_interval = REFRESH_INTERVAL
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      initiated,
  sdram_scheduler_if.slave          bus,
  output logic                      busy,
  output logic [DRAM_ADDR_BITS-1:0] DRAM_ADDR,
  output logic [BANK_BITS-1:0]      DRAM_BA,
  output logic                      DRAM_CS_N,
  output logic                      DRAM_RAS_N,
  output logic                      DRAM_CAS_N,
  output logic                      DRAM_WE_N,
  output logic                      DRAM_CKE,
  output logic [3:0]                DRAM_DQM
);
  localparam int N_RD    = CAS_Latency + burst_length + t_rp;
  localparam int N_WR    = burst_length + t_wr + t_rp;
  localparam int N_MIN   = (N_RD < N_WR) ? N_RD : N_WR;
  localparam int N_MAX   = (N_RD > N_WR) ? N_RD : N_WR;
  localparam int CNT_MAX = (t_rc > N_MAX) ? t_rc : N_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RC_LAST  = CNT_W'(t_rc - 1);
  localparam logic [CNT_W-1:0] RCD_LAST = CNT_W'(t_rcd - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(N_RD - 1);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(N_WR - 1);
  localparam logic [CNT_W-1:0] BL_C     = CNT_W'(burst_length);
  localparam logic [CNT_W-1:0] CL_C     = CNT_W'(CAS_Latency);
  localparam logic [CNT_W-1:0] CL_BL_C  = CNT_W'(CAS_Latency + burst_length);

  if (t_rc > t_rcd + N_MIN) begin : g_bad_trc
    $error("t_rc exceeds t_rcd plus the shortest access window");
  end
  if (t_rcd < 1 || t_rc < 2) begin : g_bad_timing
    $error("t_rcd must be >= 1 and t_rc >= 2");
  end
  if (bank_count != BANK_BITS || row_count != ROW_BITS || column_count != COL_BITS) begin : g_bad_geom
    $error("address geometry must match sdram_pkg");
  end

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rr_q, rr_d;
  logic                  we_q, we_d;
  logic                  grant_q, grant_d;
  logic [BANK_BITS-1:0]  bank_q, bank_d;
  logic [COL_BITS-1:0]   col_q, col_d;
  cmd_t                  cmd;
  logic                  grant;
  logic                  refresh_pending;
  logic                  refresh_ack;
  logic [CNT_W-1:0]      data_off;
  logic                  in_data;

  sdram_refresh_timer #(
    .refresh_interval (refresh_interval)
  ) u_refresh_timer (
    .clock           (clock),
    .reset           (reset),
    .enable          (state_q != ST_WAIT_INIT),
    .refresh_ack     (refresh_ack),
    .refresh_pending (refresh_pending)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_d          = rr_q;
    we_d          = we_q;
    grant_d       = grant_q;
    bank_d        = bank_q;
    col_d         = col_q;
    cmd           = CMD_NOP;
    DRAM_ADDR     = '0;
    DRAM_BA       = '0;
    bus.req_ready = 2'b00;
    refresh_ack   = 1'b0;
    grant         = (&bus.req_valid) ? rr_q : bus.req_valid[1];

    unique case (state_q)
      ST_WAIT_INIT: begin
        if (initiated) state_d = ST_READY;
      end
      ST_READY: begin
        if (refresh_pending) begin
          cmd         = CMD_REF;
          refresh_ack = 1'b1;
          cnt_d       = CNT_W'(1);
          state_d     = ST_WAIT_RC;
        end else if (|bus.req_valid) begin
          cmd                  = CMD_ACT;
          DRAM_BA              = addr_bank(bus.req_addr[grant]);
          DRAM_ADDR            = addr_row(bus.req_addr[grant]);
          bus.req_ready[grant] = 1'b1;
          grant_d              = grant;
          rr_d                 = ~grant;
          we_d                 = bus.req_we[grant];
          bank_d               = addr_bank(bus.req_addr[grant]);
          col_d                = addr_col(bus.req_addr[grant]);
          cnt_d                = CNT_W'(1);
          state_d              = (t_rcd > 1) ? ST_WAIT_RCD : ST_ACCESS;
        end
      end
      ST_WAIT_RC: begin
        if (cnt_q == RC_LAST) state_d = ST_READY;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_WAIT_RCD: begin
        if (cnt_q == RCD_LAST) state_d = ST_ACCESS;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_ACCESS: begin
        cmd       = we_q ? CMD_WRITE : CMD_READ;
        DRAM_BA   = bank_q;
        DRAM_ADDR = col_ap_addr(col_q);
        cnt_d     = CNT_W'(1);
        state_d   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (cnt_q == (we_q ? WR_LAST : RD_LAST)) state_d = ST_READY;
        else                                      cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_WAIT_INIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT_INIT;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      we_q    <= 1'b0;
      grant_q <= 1'b0;
      bank_q  <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      grant_q <= grant_d;
      bank_q  <= bank_d;
      col_q   <= col_d;
    end
  end

  // Cycles elapsed since the READA/WRITEA command, valid in ACCESS/WAIT_DONE.
  assign data_off          = (state_q == ST_ACCESS) ? '0 : cnt_q;
  assign in_data           = (state_q == ST_ACCESS) || (state_q == ST_WAIT_DONE);
  assign bus.wr_data_req   = in_data && we_q && (data_off < BL_C);
  assign bus.rd_data_valid = in_data && !we_q && (data_off >= CL_C) && (data_off < CL_BL_C);
  assign bus.data_port     = grant_q;

  assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = cmd;
  assign busy     = (state_q != ST_READY);
  assign DRAM_CKE = 1'b1;
  assign DRAM_DQM = 4'h0;

endmodule

// File: tb/tb_sdram_scheduler.sv
// Scheduler bench: random requesters checked every cycle against a cycle-stamped
// reference model, plus literal checks on power-up, a directed read and reset.
module tb_sdram_scheduler;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam int LOGN = 8192;

  logic        clock;
  logic        reset;
  logic        initiated;
  logic        busy;
  logic [12:0] dram_addr;
  logic [1:0]  dram_ba;
  logic        cs_n, ras_n, cas_n, we_n, cke;
  logic [3:0]  dqm;

  sdram_scheduler_if bus ();

  sdram_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .initiated  (initiated),
    .bus        (bus),
    .busy       (busy),
    .DRAM_ADDR  (dram_addr),
    .DRAM_BA    (dram_ba),
    .DRAM_CS_N  (cs_n),
    .DRAM_RAS_N (ras_n),
    .DRAM_CAS_N (cas_n),
    .DRAM_WE_N  (we_n),
    .DRAM_CKE   (cke),
    .DRAM_DQM   (dqm)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mode     = 0;
  int init_at  = -1;
  bit dir_pending = 0;
  bit want_act    = 0;
  int first_act   = -1;
  bit rec_grants  = 0;
  int grants[$];
  logic [1:0] rdy_seen = 2'b00;

  logic [3:0]  log_cmd [LOGN];
  logic [12:0] log_addr[LOGN];
  logic [1:0]  log_ba  [LOGN];
  logic        log_rd  [LOGN];
  logic        log_busy[LOGN];

  // Reference model: absolute cycle stamps of the next READY and the current access.
  bit          m_active, m_go, m_pend, m_rr, m_g, m_we;
  int          m_start, m_ready_at, m_acc;
  logic [24:0] m_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active   = 0; m_go = 0; m_pend = 0; m_rr = 0; m_g = 0; m_we = 0;
    m_start    = 0; m_ready_at = 0; m_acc = -100; m_addr = '0;
    rdy_seen   = 2'b00;
  endtask

  task automatic new_req(input int p);
    bus.req_valid[p] = 1'b1;
    bus.req_we[p]    = 1'($urandom_range(0, 1));
    bus.req_addr[p]  = 25'($urandom);
  endtask

  task automatic drive();
    if (cyc == init_at) initiated = 1'b1;
    if (mode == 3 && dir_pending && !bus.req_valid[0]) begin
      bus.req_valid[0] = 1'b1;
      bus.req_we[0]    = 1'b0;
      bus.req_addr[0]  = {2'd1, 13'h0123, 10'h045};
      dir_pending      = 0;
    end
    for (int p = 0; p < 2; p++) begin
      if (bus.req_valid[p] && rdy_seen[p]) bus.req_valid[p] = 1'b0;
      if (!bus.req_valid[p]) begin
        case (mode)
          1:       if ($urandom_range(0, 3) == 0) new_req(p);
          2:       new_req(p);
          default: ;
        endcase
      end
    end
  endtask

  task automatic model_check();
    logic [3:0]  e_cmd, a_cmd;
    logic [1:0]  e_ba, e_rdy;
    logic [12:0] e_addr;
    logic        e_wr, e_rd, e_busy, g;
    e_cmd = C_NOP; e_ba = 2'b00; e_addr = '0; e_rdy = 2'b00;
    e_wr = 0; e_rd = 0; e_busy = 1; g = 0;
    a_cmd = {cs_n, ras_n, cas_n, we_n};
    if (!m_active) begin
      if (initiated) m_go = 1;
    end else begin
      if (cyc >= m_ready_at) begin
        e_busy = 0;
        if (m_pend) begin
          e_cmd      = C_REF;
          m_pend     = 0;
          m_ready_at = cyc + 7;
        end else if (bus.req_valid != 2'b00) begin
          g          = (bus.req_valid == 2'b11) ? m_rr : bus.req_valid[1];
          e_rdy[g]   = 1'b1;
          m_addr     = bus.req_addr[g];
          m_we       = bus.req_we[g];
          m_g        = g;
          m_rr       = !g;
          m_acc      = cyc + 2;
          m_ready_at = m_acc + (m_we ? 8 : 9);
          e_cmd      = C_ACT;
          e_ba       = m_addr[24:23];
          e_addr     = m_addr[22:10];
        end
      end
      if (cyc == m_acc) begin
        e_cmd  = m_we ? C_WR : C_RD;
        e_ba   = m_addr[24:23];
        e_addr = {2'b00, 1'b1, m_addr[9:0]};
      end
      e_wr = m_we && (cyc >= m_acc) && (cyc <= m_acc + 3);
      e_rd = !m_we && (cyc >= m_acc + 3) && (cyc <= m_acc + 6);
      if ((cyc - m_start) % 780 == 779) m_pend = 1;
    end
    check("cycle_outputs",
          {a_cmd, dram_ba, dram_addr, bus.req_ready, bus.wr_data_req, bus.rd_data_valid, busy, cke, dqm},
          {e_cmd, e_ba, e_addr, e_rdy, e_wr, e_rd, e_busy, 1'b1, 4'h0});
    if (e_wr || e_rd) check("data_port", bus.data_port, m_g);
    if (cyc < LOGN) begin
      log_cmd[cyc]  = a_cmd;
      log_addr[cyc] = dram_addr;
      log_ba[cyc]   = dram_ba;
      log_rd[cyc]   = bus.rd_data_valid;
      log_busy[cyc] = busy;
    end
    if (want_act && a_cmd == C_ACT) begin
      first_act = cyc;
      want_act  = 0;
    end
    if (rec_grants && bus.req_ready != 2'b00) grants.push_back(int'(bus.req_ready[1]));
    rdy_seen = bus.req_ready;
    if (m_go) begin
      m_active   = 1;
      m_start    = cyc + 1;
      m_ready_at = cyc + 1;
      m_go       = 0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
    drive();
    @(negedge clock);
    if (reset) model_reset();
    else       model_check();
  endtask

  initial begin
    int cnt, errs, a;
    bit found;
    reset = 1'b1;
    initiated = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    model_reset();
    repeat (3) step();
    reset   = 1'b0;
    init_at = 10;

    // Power-up: idle until just past the first refresh.
    while (cyc < 800) step();
    check("first_ref_cmd", log_cmd[791], C_REF);
    cnt = 0;
    for (int c = 4; c < 791; c++) if (log_cmd[c] != C_NOP) cnt++;
    check("nop_before_first_ref", cnt, 0);
    cnt = 0;
    for (int c = 4; c <= 800; c++) if (log_cmd[c] == C_REF) cnt++;
    check("single_ref_count", cnt, 1);

    // Directed read on port 0.
    mode = 3; dir_pending = 1; want_act = 1;
    repeat (25) step();
    check("dir_act_found", first_act >= 0, 1);
    if (first_act >= 0) begin
      a = first_act;
      check("dir_act", {log_cmd[a], log_ba[a], log_addr[a]}, {C_ACT, 2'd1, 13'h0123});
      check("dir_reada", {log_cmd[a+2], log_ba[a+2], log_addr[a+2]}, {C_RD, 2'd1, 13'h0445});
      check("dir_rd_window",
            {log_rd[a+4], log_rd[a+5], log_rd[a+6], log_rd[a+7], log_rd[a+8], log_rd[a+9]},
            6'b011110);
      check("dir_ready_after", {log_busy[a+10], log_busy[a+11]}, 2'b10);
    end

    // Random single/dual requesters, then saturated alternating traffic.
    mode = 1;
    while (cyc < 2400) step();
    mode = 2; rec_grants = 1;
    while (cyc < 4000) step();
    rec_grants = 0;
    errs = 0;
    for (int i = 1; i < grants.size(); i++) if (grants[i] == grants[i-1]) errs++;
    check("grant_alternation", errs, 0);
    check("grant_count_min", grants.size() >= 8, 1);

    // Reset in the middle of a read burst.
    mode = 0;
    repeat (20) step();
    mode = 3; dir_pending = 1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (bus.rd_data_valid) found = 1;
    end
    check("wait_rd_window", found, 1);
    @(posedge clock);
    cyc++;
    #1;
    drive();
    #2;
    reset = 1'b1;
    initiated = 1'b0;
    bus.req_valid = 2'b00;
    mode = 0;
    #1;
    check("rst_cmd_pins", {cs_n, ras_n, cas_n, we_n, dram_ba, dram_addr}, {C_NOP, 2'b00, 13'h0000});
    check("rst_strobes", {bus.rd_data_valid, bus.wr_data_req, bus.req_ready, bus.data_port}, 5'b00000);
    check("rst_busy_cke_dqm", {busy, cke, dqm}, {1'b1, 1'b1, 4'h0});
    @(negedge clock);
    model_reset();
    repeat (3) step();
    reset   = 1'b0;
    init_at = cyc + 5;
    repeat (4) step();
    check("reinit_wait_busy", busy, 1'b1);
    mode = 1;
    repeat (900) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
